// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : enc_pkg
// Brief    : Shared sizes, FSM state type and mode constants for the
//            4-to-2 event encoder.
// Revision : 1.0
// ============================================================================
package enc_pkg;

    localparam int NREQ   = 4;
    localparam int CODE_W = 2;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [CODE_W-1:0] idx);
        onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prio_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : prio_pick_4
// Brief    : Combinational picker: highest set index (fixed) or first set
//            index searching upward from i_start modulo 4 (round-robin).
// Revision : 1.0
// ============================================================================
module prio_pick_4
    import enc_pkg::*;
(
    input  logic [NREQ-1:0]   i_mask,
    input  logic [CODE_W-1:0] i_start,
    input  logic              i_mode,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_any
);

    logic [CODE_W-1:0] w_pos;

    always_comb begin
        o_idx = '0;
        o_any = |i_mask;
        w_pos = '0;
        if (i_mode == MODE_RR) begin
            // Walk the offsets farthest-first so the nearest hit is the last write.
            for (int k = NREQ-1; k >= 0; k--) begin
                w_pos = i_start + CODE_W'(k);
                if (i_mask[w_pos]) begin
                    o_idx = w_pos;
                end
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (i_mask[k]) begin
                    o_idx = CODE_W'(k);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/event_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : event_encoder_4x2
// Brief    : Sticky 4-request capture, arbitration and 2-bit code emission
//            over a valid/ready handshake, with merged-request overflow pulse.
// Revision : 1.0
// ============================================================================
module event_encoder_4x2
    import enc_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic              ready_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    output logic [NREQ-1:0]   pending_o,
    output logic              overflow_o
);

    localparam logic c_mode = (RR_MODE != 0) ? MODE_RR : MODE_FIXED;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic [CODE_W-1:0] r_ptr;
    logic [NREQ-1:0]   r_pending;
    logic              r_overflow;

    logic              w_hs;
    logic [NREQ-1:0]   w_clr;
    logic [NREQ-1:0]   w_eff;
    logic [CODE_W-1:0] w_start;
    logic              w_ovf;
    logic [CODE_W-1:0] w_pick_idx;
    logic              w_pick_any;

    always_comb begin
        w_hs  = (r_state == PRESENT) && ready_i;
        w_clr = w_hs ? onehot(r_code) : '0;
        // New requests OR in after the clear, so a same-edge re-request survives.
        w_eff = (r_pending & ~w_clr) | req;
        // The grant being consumed this edge already counts as the last one served.
        w_start = (w_hs ? r_code : r_ptr) + CODE_W'(1);
        w_ovf   = |(req & r_pending & ~w_clr);
    end

    prio_pick_4 u_pick (
        .i_mask  (w_eff),
        .i_start (w_start),
        .i_mode  (c_mode),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = PRESENT;
                    w_code_nxt  = w_pick_idx;
                end
            end
            PRESENT: begin
                if (w_hs) begin
                    if (w_pick_any) begin
                        w_code_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_code     <= '0;
            r_ptr      <= '1;
            r_pending  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_code     <= w_code_nxt;
            r_pending  <= w_eff;
            r_overflow <= w_ovf;
            if (w_hs) begin
                r_ptr <= r_code;
            end
        end
    end

    assign code_o     = r_code;
    assign valid_o    = (r_state == PRESENT);
    assign pending_o  = r_pending;
    assign overflow_o = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_event_encoder_4x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_encoder_4x2
// Brief    : Vector-table bench for a fixed-priority and a round-robin
//            instance; expected results flow through a scoreboard queue.
// Revision : 1.0
// ============================================================================
module tb_event_encoder_4x2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_f, req_r;
    logic       rdy_f, rdy_r;
    logic [1:0] code_f, code_r;
    logic       valid_f, valid_r;
    logic [3:0] pend_f, pend_r;
    logic       ovf_f, ovf_r;

    always #5 clk = ~clk;

    event_encoder_4x2 #(.RR_MODE(0)) u_dut_fixed (
        .clk        (clk),
        .rst        (rst),
        .req        (req_f),
        .ready_i    (rdy_f),
        .code_o     (code_f),
        .valid_o    (valid_f),
        .pending_o  (pend_f),
        .overflow_o (ovf_f)
    );

    event_encoder_4x2 #(.RR_MODE(1)) u_dut_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (req_r),
        .ready_i    (rdy_r),
        .code_o     (code_r),
        .valid_o    (valid_r),
        .pending_o  (pend_r),
        .overflow_o (ovf_r)
    );

    typedef struct {
        bit         sel;
        bit         rst;
        logic [3:0] req;
        bit         rdy;
        bit         e_valid;
        bit         chk_code;
        logic [1:0] e_code;
        logic [3:0] e_pend;
        bit         e_ovf;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Expected values describe the outputs just after the edge the inputs are applied to.
    function automatic vec_t mk(bit sel, bit r, logic [3:0] rq, bit rdy,
                                bit ev, logic [1:0] ec, logic [3:0] ep, bit eo);
        vec_t t;
        t.sel      = sel;
        t.rst      = r;
        t.req      = rq;
        t.rdy      = rdy;
        t.e_valid  = ev;
        t.chk_code = ev | r;
        t.e_code   = ec;
        t.e_pend   = ep;
        t.e_ovf    = eo;
        return t;
    endfunction

    task automatic check(input int idx, input vec_t e);
        logic [1:0] a_code;
        logic       a_valid, a_ovf;
        logic [3:0] a_pend;
        bit         ok;
        a_code  = e.sel ? code_r  : code_f;
        a_valid = e.sel ? valid_r : valid_f;
        a_pend  = e.sel ? pend_r  : pend_f;
        a_ovf   = e.sel ? ovf_r   : ovf_f;
        ok = (a_valid === e.e_valid) && (a_pend === e.e_pend) && (a_ovf === e.e_ovf) &&
             (!e.chk_code || (a_code === e.e_code));
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL vec%0d %s valid/code/pending/ovf got %b/%b/%b/%b want %b/%b/%b/%b",
                     idx, e.sel ? "rr" : "fixed", a_valid, a_code, a_pend, a_ovf,
                     e.e_valid, e.e_code, e.e_pend, e.e_ovf);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req_f = '0;
        req_r = '0;
        rdy_f = 1'b0;
        rdy_r = 1'b0;

        //               sel rst req      rdy  valid code   pending  ovf
        // reset held with requests asserted, then release
        vecs.push_back(mk(0, 1, 4'b1111, 0,   0, 2'b00, 4'b0000, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 0,   0, 2'b00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   0, 2'b00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   0, 2'b00, 4'b0000, 0));
        // single request
        vecs.push_back(mk(0, 0, 4'b0100, 1,   1, 2'b10, 4'b0100, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1,   0, 2'b00, 4'b0000, 0));
        // fixed priority with backpressure
        vecs.push_back(mk(0, 0, 4'b1011, 0,   1, 2'b11, 4'b1011, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   1, 2'b11, 4'b1011, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   1, 2'b11, 4'b1011, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1,   1, 2'b01, 4'b0011, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1,   1, 2'b00, 4'b0001, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1,   0, 2'b00, 4'b0000, 0));
        // overflow on a repeated request
        vecs.push_back(mk(0, 0, 4'b0010, 0,   1, 2'b01, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 4'b0010, 0,   1, 2'b01, 4'b0010, 1));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   1, 2'b01, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 1,   0, 2'b00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   0, 2'b00, 4'b0000, 0));
        // set/clear collision, then reset mid-operation
        vecs.push_back(mk(0, 0, 4'b0010, 0,   1, 2'b01, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 4'b0010, 1,   1, 2'b01, 4'b0010, 0));
        vecs.push_back(mk(0, 0, 4'b1000, 0,   1, 2'b01, 4'b1010, 0));
        vecs.push_back(mk(0, 1, 4'b1111, 1,   0, 2'b00, 4'b0000, 0));
        vecs.push_back(mk(0, 0, 4'b0000, 0,   0, 2'b00, 4'b0000, 0));
        // round-robin rotation, then wrap past the last grant
        vecs.push_back(mk(1, 0, 4'b1111, 1,   1, 2'b00, 4'b1111, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1,   1, 2'b01, 4'b1110, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1,   1, 2'b10, 4'b1100, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1,   1, 2'b11, 4'b1000, 0));
        vecs.push_back(mk(1, 0, 4'b1001, 1,   1, 2'b00, 4'b1001, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1,   1, 2'b11, 4'b1000, 0));
        vecs.push_back(mk(1, 0, 4'b0000, 1,   0, 2'b00, 4'b0000, 0));

        foreach (vecs[i]) begin
            vec_t v;
            vec_t e;
            v = vecs[i];
            @(negedge clk);
            rst   = v.rst;
            req_f = v.sel ? 4'b0000 : v.req;
            rdy_f = v.sel ? 1'b0    : v.rdy;
            req_r = v.sel ? v.req   : 4'b0000;
            rdy_r = v.sel ? v.rdy   : 1'b0;
            sb.push_back(v);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(i, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
